// File: rtl/multdiv_pkg.sv
// Shared types for the sequential multiply/divide unit: FSM states,
// operation encoding and the iteration-counter sizing rule.
package multdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    OP_MUL,
    OP_DIV
  } op_t;

  // Counter width for the default 32-bit configuration; counts 0..WIDTH
  localparam int DEFAULT_WIDTH = 32;
  localparam int CNT_W         = $clog2(DEFAULT_WIDTH + 1);

  // Counter width for an arbitrary operand width (must hold the value WIDTH)
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/multdiv_seq_booth_step.sv
// One radix-2 Booth iteration on the {hi, lo, q-1} register.
// The add is done one bit wider than hi so that subtracting the most
// negative multiplicand cannot wrap before the arithmetic shift.
module booth_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc_in,
  input  logic [WIDTH-1:0] multiplicand,
  output logic [2*WIDTH:0] acc_out
);

  logic [WIDTH:0] hi_ext;
  logic [WIDTH:0] mcand_ext;
  logic [WIDTH:0] sum;

  // Add +A / -A / 0 to hi from {lo[0], q-1}, then shift the whole register right
  always_comb begin
    hi_ext    = {acc_in[2*WIDTH], acc_in[2*WIDTH:WIDTH+1]};
    mcand_ext = {multiplicand[WIDTH-1], multiplicand};
    case (acc_in[1:0])
      2'b01:   sum = hi_ext + mcand_ext;
      2'b10:   sum = hi_ext - mcand_ext;
      default: sum = hi_ext;
    endcase
    acc_out = {sum, acc_in[WIDTH:1]};
  end

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiply/divide coprocessor, one radix-2 step per clock.
// Optional feature macro: MULTDIV_DIV_EN builds the restoring divider,
// its sign fix-up and divide-by-zero detection; without it only MULT runs
// and any DIV start returns an exception.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_hi,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  op_t              op_q;
  logic [CW-1:0]    iter_cnt;
  logic [WIDTH-1:0] a_lat;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] booth_next;
  logic [2*WIDTH:0] step_next;

  logic start_mul;
  logic start_div;
  logic start_both;
  logic early_exit;
  logic iter_done;

`ifdef MULTDIV_DIV_EN
  logic [WIDTH-1:0] b_lat;
  logic [WIDTH-1:0] a_mag_in;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   div_shifted;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [2*WIDTH:0] div_next;
  logic             div_zero;
  logic [WIDTH-1:0] quo_mag;
  logic [WIDTH-1:0] rem_mag;
  logic             div_ovf;
`endif

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc_in      (acc),
    .multiplicand(a_lat),
    .acc_out     (booth_next)
  );

  // Decode the start pulses and decide whether this start bypasses RUN
  always_comb begin
    start_mul  = ctrl_MULT & ~ctrl_DIV;
    start_div  = ctrl_DIV & ~ctrl_MULT;
    start_both = ctrl_MULT & ctrl_DIV;
    iter_done  = (iter_cnt == CW'(WIDTH));
`ifdef MULTDIV_DIV_EN
    div_zero   = start_div & (data_operandB == '0);
    early_exit = start_both | div_zero;
`else
    early_exit = start_both | start_div;
`endif
  end

`ifdef MULTDIV_DIV_EN
  // Restoring divide step on magnitudes: rem in hi, quotient shifting in lo
  always_comb begin
    a_mag_in    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag       = b_lat[WIDTH-1] ? -b_lat : b_lat;
    div_shifted = {acc[2*WIDTH:WIDTH+1], acc[WIDTH]};
    div_ge      = (div_shifted >= {1'b0, b_mag});
    div_diff    = div_shifted[WIDTH-1:0] - b_mag;
    div_next    = {(div_ge ? div_diff : div_shifted[WIDTH-1:0]),
                   acc[WIDTH-1:1], div_ge, 1'b0};
    quo_mag     = acc[WIDTH:1];
    rem_mag     = acc[2*WIDTH:WIDTH+1];
    div_ovf     = (a_lat == {1'b1, {(WIDTH-1){1'b0}}}) && (b_lat == '1);
    step_next   = (op_q == OP_DIV) ? div_next : booth_next;
  end
`else
  // Only the Booth datapath exists, so every RUN step is a multiply step
  always_comb begin
    step_next = booth_next;
  end
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: starts only count in IDLE, RUN ends after WIDTH steps plus a finalise cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (early_exit) begin
          state_next = DONE;
        end else if (start_mul | start_div) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (iter_done) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs: latch on start, iterate in RUN, publish results on entering DONE
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q           <= OP_MUL;
      iter_cnt       <= '0;
      a_lat          <= '0;
      acc            <= '0;
      busy           <= 1'b0;
      data_result    <= '0;
      data_hi        <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIV_EN
      b_lat          <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (early_exit) begin
            busy           <= 1'b1;
            data_resultRDY <= 1'b1;
            data_exception <= 1'b1;
            data_result    <= '0;
`ifdef MULTDIV_DIV_EN
            data_hi        <= div_zero ? data_operandA : '0;
`else
            data_hi        <= '0;
`endif
          end else if (start_mul | start_div) begin
            busy           <= 1'b1;
            data_result    <= '0;
            data_hi        <= '0;
            data_exception <= 1'b0;
            a_lat          <= data_operandA;
            iter_cnt       <= '0;
`ifdef MULTDIV_DIV_EN
            b_lat          <= data_operandB;
            if (start_div) begin
              op_q <= OP_DIV;
              acc  <= {{WIDTH{1'b0}}, a_mag_in, 1'b0};
            end else begin
              op_q <= OP_MUL;
              acc  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
            end
`else
            op_q           <= OP_MUL;
            acc            <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
`endif
          end
        end
        RUN: begin
          if (!iter_done) begin
            acc      <= step_next;
            iter_cnt <= iter_cnt + CW'(1);
          end else begin
            data_resultRDY <= 1'b1;
            if (op_q == OP_DIV) begin
`ifdef MULTDIV_DIV_EN
              data_result    <= (a_lat[WIDTH-1] ^ b_lat[WIDTH-1]) ? -quo_mag : quo_mag;
              data_hi        <= a_lat[WIDTH-1] ? -rem_mag : rem_mag;
              data_exception <= div_ovf;
`else
              data_result    <= '0;
              data_hi        <= '0;
              data_exception <= 1'b1;
`endif
            end else begin
              data_result    <= acc[WIDTH:1];
              data_hi        <= acc[2*WIDTH:WIDTH+1];
              data_exception <= (acc[2*WIDTH:WIDTH+1] != {WIDTH{acc[WIDTH]}});
            end
          end
        end
        DONE: begin
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
        default: begin
          busy           <= 1'b0;
          data_resultRDY <= 1'b0;
        end
      endcase
    end
  end

endmodule
